// File: rtl/cordic_rotate_pipe.sv
// Pipelined rotation-mode CORDIC.
// A quadrant-fold register brings the angle into [-90, +90) deg, then STAGES
// registered micro-rotations drive the residual angle toward zero. All
// registers advance together on a single global enable, so the pipe stalls as
// a whole when the output is held and no bubble collapsing takes place.

// Arctangent table: atan(2^-addr) scaled so that 2^32 is one full turn.
// Each stage owns an instance with a constant address, so the lookup folds
// down to a constant.
module atan_table_pipe (
   input  logic [4:0]  addr,
   output logic [31:0] atan
);

   // Constant lookup, rounded to nearest
   always_comb begin
      atan = 32'd0;
      case (addr)
         5'd0:  atan = 32'h2000_0000;
         5'd1:  atan = 32'h12E4_051E;
         5'd2:  atan = 32'h09FB_385B;
         5'd3:  atan = 32'h0511_11D4;
         5'd4:  atan = 32'h028B_0D43;
         5'd5:  atan = 32'h0145_D7E1;
         5'd6:  atan = 32'h00A2_F61E;
         5'd7:  atan = 32'h0051_7C55;
         5'd8:  atan = 32'h0028_BE53;
         5'd9:  atan = 32'h0014_5F2F;
         5'd10: atan = 32'h000A_2F98;
         5'd11: atan = 32'h0005_17CC;
         5'd12: atan = 32'h0002_8BE6;
         5'd13: atan = 32'h0001_45F3;
         5'd14: atan = 32'h0000_A2FA;
         5'd15: atan = 32'h0000_517D;
         5'd16: atan = 32'h0000_28BE;
         5'd17: atan = 32'h0000_145F;
         5'd18: atan = 32'h0000_0A30;
         5'd19: atan = 32'h0000_0518;
         5'd20: atan = 32'h0000_028C;
         5'd21: atan = 32'h0000_0146;
         5'd22: atan = 32'h0000_00A3;
         5'd23: atan = 32'h0000_0051;
         5'd24: atan = 32'h0000_0029;
         5'd25: atan = 32'h0000_0014;
         5'd26: atan = 32'h0000_000A;
         5'd27: atan = 32'h0000_0005;
         5'd28: atan = 32'h0000_0003;
         5'd29: atan = 32'h0000_0001;
         default: atan = 32'd0;
      endcase
   end

endmodule

module cordic_rotate_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 16   // 1..30
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] y_i,
   input  logic [31:0]             angle_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [WIDTH+1:0] x_o,
   output logic signed [WIDTH+1:0] y_o,
   output logic signed [31:0]      angle_res_o
);

   // Two guard bits absorb the CORDIC gain plus the sqrt(2) vector growth,
   // and make negating the most-negative input exact.
   localparam int DW = WIDTH + 2;

   // Index 0 is the fold register; index i+1 is the output of stage i.
   logic signed [DW-1:0] x_pipe     [0:STAGES];
   logic signed [DW-1:0] y_pipe     [0:STAGES];
   logic [31:0]          z_pipe     [0:STAGES];
   logic                 valid_pipe [0:STAGES];

   logic                 adv;
   logic signed [DW-1:0] x_ext;
   logic signed [DW-1:0] y_ext;
   logic                 fold;

   // One enable for the whole pipe: move whenever the output slot is free
   // or being drained this cycle.
   assign adv        = !out_valid_o || out_ready_i;
   assign in_ready_o = adv;

   assign x_ext = {{2{x_i[WIDTH-1]}}, x_i};
   assign y_ext = {{2{y_i[WIDTH-1]}}, y_i};

   // Angles in [90, 270) deg are rotated by 180 deg first: negate the vector
   // and flip the angle MSB. 0x40000000 folds, 0xC0000000 does not.
   assign fold = angle_i[31] ^ angle_i[30];

   // Fold register: captures the incoming sample with its quadrant folded away
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_pipe[0] <= 1'b0;
         x_pipe[0]     <= '0;
         y_pipe[0]     <= '0;
         z_pipe[0]     <= '0;
      end else if (adv) begin
         valid_pipe[0] <= in_valid_i;
         if (fold) begin
            x_pipe[0] <= -x_ext;
            y_pipe[0] <= -y_ext;
            z_pipe[0] <= angle_i + 32'h8000_0000;
         end else begin
            x_pipe[0] <= x_ext;
            y_pipe[0] <= y_ext;
            z_pipe[0] <= angle_i;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [31:0]          atan_val;
         logic signed [DW-1:0] x_sh;
         logic signed [DW-1:0] y_sh;

         atan_table_pipe u_atan (
            .addr (5'(gi)),
            .atan (atan_val)
         );

         // Arithmetic shifts truncate toward -inf; no rounding is applied.
         assign x_sh = x_pipe[gi] >>> gi;
         assign y_sh = y_pipe[gi] >>> gi;

         // Micro-rotation: turn toward zero residual angle by +/- atan(2^-gi)
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               valid_pipe[gi+1] <= 1'b0;
               x_pipe[gi+1]     <= '0;
               y_pipe[gi+1]     <= '0;
               z_pipe[gi+1]     <= '0;
            end else if (adv) begin
               valid_pipe[gi+1] <= valid_pipe[gi];
               if (!z_pipe[gi][31]) begin
                  x_pipe[gi+1] <= x_pipe[gi] - y_sh;
                  y_pipe[gi+1] <= y_pipe[gi] + x_sh;
                  z_pipe[gi+1] <= z_pipe[gi] - atan_val;
               end else begin
                  x_pipe[gi+1] <= x_pipe[gi] + y_sh;
                  y_pipe[gi+1] <= y_pipe[gi] - x_sh;
                  z_pipe[gi+1] <= z_pipe[gi] + atan_val;
               end
            end
         end
      end
   endgenerate

   assign out_valid_o = valid_pipe[STAGES];
   assign x_o         = x_pipe[STAGES];
   assign y_o         = y_pipe[STAGES];
   assign angle_res_o = z_pipe[STAGES];

endmodule

// File: tb/tb_cordic_rotate_pipe.sv
// Directed bench for cordic_rotate_pipe: fixed-angle vectors with
// hand-computed results, a backpressured stream against an ideal
// floating-point rotation, an asynchronous reset mid-stall, and a
// single-stage build with exact expectations.
module tb_cordic_rotate_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // main instance, 16 stages
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] x_in = '0;
   logic signed [15:0] y_in = '0;
   logic [31:0]        angle_in = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [17:0] x_out;
   logic signed [17:0] y_out;
   logic signed [31:0] angle_res;

   // single-stage instance
   logic               in_valid1 = 1'b0;
   logic               in_ready1;
   logic signed [15:0] x_in1 = '0;
   logic signed [15:0] y_in1 = '0;
   logic [31:0]        angle_in1 = '0;
   logic               out_valid1;
   logic               out_ready1 = 1'b1;
   logic signed [17:0] x_out1;
   logic signed [17:0] y_out1;
   logic signed [31:0] angle_res1;

   int  n_vec = 0;
   int  n_bad = 0;
   real gain;

   always #5 clk = ~clk;

   cordic_rotate_pipe #(.WIDTH(16), .STAGES(16)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .x_i         (x_in),
      .y_i         (y_in),
      .angle_i     (angle_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .x_o         (x_out),
      .y_o         (y_out),
      .angle_res_o (angle_res)
   );

   cordic_rotate_pipe #(.WIDTH(16), .STAGES(1)) u_dut1 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid1),
      .in_ready_o  (in_ready1),
      .x_i         (x_in1),
      .y_i         (y_in1),
      .angle_i     (angle_in1),
      .out_valid_o (out_valid1),
      .out_ready_i (out_ready1),
      .x_o         (x_out1),
      .y_o         (y_out1),
      .angle_res_o (angle_res1)
   );

   task automatic check_val(input string tag, input int got, input int want, input int tol);
      int d;
      n_vec++;
      d = got - want;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, want, tol);
      end
   endtask

   // ideal gain-scaled rotation
   task automatic ideal(input int xv, input int yv, input logic [31:0] ang,
                        output int ex, output int ey);
      real th;
      th = 2.0 * 3.14159265358979 * (real'(ang) / 4294967296.0);
      ex = int'(gain * (real'(xv) * $cos(th) - real'(yv) * $sin(th)));
      ey = int'(gain * (real'(xv) * $sin(th) + real'(yv) * $cos(th)));
   endtask

   // push one sample into the empty 16-stage pipe, wait for it and drain it
   task automatic run_one(input int xv, input int yv, input logic [31:0] ang,
                          output int ox, output int oy, output int lat, output int res);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x_in      = 16'(xv);
      y_in      = 16'(yv);
      angle_in  = ang;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (lat < 100) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      ox  = int'(x_out);
      oy  = int'(y_out);
      res = int'(angle_res);
      $display("vec x=%0d y=%0d ang=%08h -> x_o=%0d y_o=%0d lat=%0d", xv, yv, ang, ox, oy, lat);
      @(posedge clk);
   endtask

   initial begin
      int ox, oy, lat, res;
      real p;
      int ex_q[$];
      int ey_q[$];
      int sent, recv, cycles, hs_err, stab_err, stale, ex, ey;
      logic prev_stall, acc;
      logic signed [17:0] prev_x, prev_y;
      logic [31:0] ang;

      gain = 1.0;
      p = 1.0;
      for (int i = 0; i < 16; i++) begin
         gain = gain * $sqrt(1.0 + p);
         p = p / 4.0;
      end

      // reset state
      #12;
      check_val("rst_valid", int'(out_valid), 0, 0);
      check_val("rst_x", int'(x_out), 0, 0);
      check_val("rst_res", int'(angle_res), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("idle_ready", int'(in_ready), 1, 0);

      // directed angles, x=19898 y=0
      run_one(19898, 0, 32'h0000_0000, ox, oy, lat, res);
      check_val("lat0", lat, 17, 0);
      check_val("x0", ox, 32767, 6);
      check_val("y0", oy, 0, 6);
      check_val("res0", res, 0, 20877);
      run_one(19898, 0, 32'h2000_0000, ox, oy, lat, res);
      check_val("x45", ox, 23170, 6);
      check_val("y45", oy, 23170, 6);
      run_one(19898, 0, 32'h4000_0000, ox, oy, lat, res);
      check_val("x90", ox, 0, 6);
      check_val("y90", oy, 32767, 6);
      run_one(19898, 0, 32'h8000_0000, ox, oy, lat, res);
      check_val("x180", ox, -32767, 6);
      check_val("y180", oy, 0, 6);
      run_one(19898, 0, 32'hC000_0000, ox, oy, lat, res);
      check_val("xm90", ox, 0, 6);
      check_val("ym90", oy, -32767, 6);
      run_one(19898, 0, 32'h7FFF_FFFF, ox, oy, lat, res);
      check_val("x7fff", ox, -32767, 6);
      check_val("y7fff", oy, 0, 6);
      // most-negative input, unfolded and folded
      run_one(-32768, 0, 32'h0000_0000, ox, oy, lat, res);
      check_val("xneg0", ox, -53961, 6);
      run_one(-32768, 0, 32'h8000_0000, ox, oy, lat, res);
      check_val("xneg180", ox, 53961, 6);
      check_val("yneg180", oy, 0, 6);

      // backpressured stream of 40 angles
      for (int k = 0; k < 40; k++) begin
         ang = 32'(k) * 32'h0600_0000;
         ideal(12000, -9000, ang, ex, ey);
         ex_q.push_back(ex);
         ey_q.push_back(ey);
      end
      sent = 0; recv = 0; cycles = 0; hs_err = 0; stab_err = 0;
      prev_stall = 1'b0; prev_x = '0; prev_y = '0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      x_in     = 16'sd12000;
      y_in     = -16'sd9000;
      angle_in = 32'h0;
      while (recv < 40 && cycles < 2000) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         cycles++;
         if (in_ready != !(out_valid && !out_ready)) hs_err++;
         if (prev_stall && (x_out != prev_x || y_out != prev_y || !out_valid)) stab_err++;
         prev_stall = out_valid && !out_ready;
         prev_x = x_out;
         prev_y = y_out;
         if (out_valid && out_ready) begin
            $display("stream #%0d x_o=%0d y_o=%0d want %0d %0d", recv, x_out, y_out, ex_q[recv], ey_q[recv]);
            check_val("sx", int'(x_out), ex_q[recv], 6);
            check_val("sy", int'(y_out), ey_q[recv], 6);
            recv++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            if (sent < 40) angle_in = 32'(sent) * 32'h0600_0000;
            else in_valid = 1'b0;
         end
      end
      check_val("stream_recv", recv, 40, 0);
      check_val("stream_sent", sent, 40, 0);
      check_val("handshake", hs_err, 0, 0);
      check_val("stall_stable", stab_err, 0, 0);

      // fill with output stalled, then reset mid-stall
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x_in      = 16'sd19898;
      y_in      = 16'sd0;
      angle_in  = 32'h0;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!out_valid && cycles < 60);
      check_val("stall_full", int'(out_valid), 1, 0);
      check_val("stall_ready", int'(in_ready), 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_valid", int'(out_valid), 0, 0);
      check_val("async_x", int'(x_out), 0, 0);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check_val("no_stale", stale, 0, 0);
      run_one(19898, 0, 32'h0000_0000, ox, oy, lat, res);
      check_val("post_rst_lat", lat, 17, 0);
      check_val("post_rst_x", ox, 32767, 6);

      // single-stage build: one exact 45 deg step
      @(posedge clk); #1;
      in_valid1 = 1'b1;
      x_in1     = 16'sd19898;
      y_in1     = 16'sd0;
      angle_in1 = 32'h1000_0000;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 1;
      while (lat < 20) begin
         @(negedge clk);
         if (out_valid1) break;
         @(posedge clk);
         lat++;
      end
      $display("s1 x_o=%0d y_o=%0d res=%08h lat=%0d", x_out1, y_out1, angle_res1, lat);
      check_val("s1_lat", lat, 2, 0);
      check_val("s1_x", int'(x_out1), 19898, 0);
      check_val("s1_y", int'(y_out1), 19898, 0);
      check_val("s1_res", int'(angle_res1), int'(32'hF000_0000), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
